// File: rtl/frame_buf_pkg.sv
// Shared frame-buffer definitions: per-buffer ownership encodings and the
// default SDRAM frame geometry used by both the SDRAM controller and the
// frame-buffer manager.
package frame_buf_pkg;

  typedef logic [1:0] buf_state_t;

  localparam buf_state_t BUF_FREE    = 2'd0;
  localparam buf_state_t BUF_WRITING = 2'd1;
  localparam buf_state_t BUF_READY   = 2'd2;
  localparam buf_state_t BUF_READING = 2'd3;

  localparam int unsigned DEF_NUM_BUF     = 3;
  localparam int unsigned DEF_ADDR_W      = 24;
  localparam int unsigned DEF_BUF_SHIFT   = 19;
  localparam int unsigned DEF_FRAME_WORDS = 307200;
  localparam int unsigned DEF_BURST_LEN   = 256;
  localparam int unsigned DEF_CNT_W       = 16;

endpackage

// File: rtl/buf_pick.sv
// Lowest-index FREE buffer picker with an exclusion mask.
module buf_pick #(
  parameter int unsigned NUM_BUF = 3
) (
  input  logic [NUM_BUF-1:0] free_mask,
  input  logic [NUM_BUF-1:0] excl_mask,
  output logic [1:0]         idx,
  output logic               found
);

  // Priority encode the first buffer that is free and not excluded.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_BUF; i++) begin
      if (!found && free_mask[i] && !excl_mask[i]) begin
        idx   = 2'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_buf_mgr.sv
// N-buffer frame-buffer manager: tracks ownership of rotating frame regions
// and generates burst base addresses for the SDRAM write and read engines.
// The reader only ever sees complete frames; stale frames are dropped and
// the last frame is repeated when nothing new is ready.
module frame_buf_mgr
  import frame_buf_pkg::*;
#(
  parameter int unsigned NUM_BUF     = DEF_NUM_BUF,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned BUF_SHIFT   = DEF_BUF_SHIFT,
  parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int unsigned BURST_LEN   = DEF_BURST_LEN,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_sop,
  input  logic              wr_burst_done,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_buf,
  output logic              wr_active,
  output logic              wr_frame_done,
  input  logic              rd_sop,
  input  logic              rd_burst_done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        rd_buf,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  repeat_cnt
);

  localparam int unsigned NB = FRAME_WORDS / BURST_LEN;
  localparam int unsigned CW = $clog2(NB + 1);

  buf_state_t buf_st [NUM_BUF];
  buf_state_t st_mid [NUM_BUF];
  buf_state_t st_nxt [NUM_BUF];

  logic [CW-1:0]      wr_cnt;
  logic [CW-1:0]      rd_cnt;
  logic               wr_complete;
  logic               drop_cmp;
  logic               drop_wr;
  logic               rd_take;
  logic [1:0]         rd_take_idx;
  logic [NUM_BUF-1:0] free_mask;
  logic [NUM_BUF-1:0] excl_mask;
  logic [1:0]         pick_idx;
  logic               pick_found;
  logic [1:0]         wr_new_idx;

  function automatic logic [ADDR_W-1:0] region_base(input logic [1:0] idx);
    return ADDR_W'(idx) << BUF_SHIFT;
  endfunction

  // Completion is applied before the reader's claim so a frame finishing this
  // cycle is taken immediately; the free mask already counts the buffer that
  // wr_sop is about to abort.
  always_comb begin
    st_mid      = buf_st;
    drop_cmp    = 1'b0;
    rd_take     = 1'b0;
    rd_take_idx = '0;
    free_mask   = '0;
    excl_mask   = '0;
    wr_complete = wr_active && wr_burst_done && !wr_sop && (wr_cnt == CW'(NB - 1));
    if (wr_complete) begin
      for (int unsigned i = 0; i < NUM_BUF; i++) begin
        if (st_mid[i] == BUF_READY) begin
          st_mid[i] = BUF_FREE;
          drop_cmp  = 1'b1;
        end
        if (2'(i) == wr_buf) st_mid[i] = BUF_READY;
      end
    end
    if (rd_sop) begin
      for (int unsigned i = 0; i < NUM_BUF; i++) begin
        if (st_mid[i] == BUF_READY) begin
          rd_take     = 1'b1;
          rd_take_idx = 2'(i);
        end
      end
    end
    for (int unsigned i = 0; i < NUM_BUF; i++) begin
      if (rd_take) begin
        if (st_mid[i] == BUF_READING) begin
          st_mid[i] = BUF_FREE;
        end else if (st_mid[i] == BUF_READY) begin
          st_mid[i]    = BUF_READING;
          excl_mask[i] = 1'b1;
        end
      end
      free_mask[i] = (st_mid[i] == BUF_FREE) || (wr_sop && st_mid[i] == BUF_WRITING);
    end
  end

  buf_pick #(
    .NUM_BUF(NUM_BUF)
  ) u_buf_pick (
    .free_mask(free_mask),
    .excl_mask(excl_mask),
    .idx      (pick_idx),
    .found    (pick_found)
  );

  // Writer start: abort any frame in flight, then claim a FREE buffer or,
  // failing that, overwrite the READY one.
  always_comb begin
    st_nxt     = st_mid;
    drop_wr    = 1'b0;
    wr_new_idx = pick_idx;
    if (wr_sop) begin
      for (int unsigned i = 0; i < NUM_BUF; i++) begin
        if (st_nxt[i] == BUF_WRITING) begin
          st_nxt[i] = BUF_FREE;
          drop_wr   = 1'b1;
        end
      end
      for (int unsigned i = 0; i < NUM_BUF; i++) begin
        if (pick_found) begin
          if (2'(i) == pick_idx) st_nxt[i] = BUF_WRITING;
        end else if (st_nxt[i] == BUF_READY) begin
          st_nxt[i]  = BUF_WRITING;
          wr_new_idx = 2'(i);
          drop_wr    = 1'b1;
        end
      end
    end
  end

  // Registered ownership, address generation and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_BUF; i++) buf_st[i] <= BUF_FREE;
      wr_addr       <= '0;
      wr_buf        <= '0;
      wr_active     <= 1'b0;
      wr_frame_done <= 1'b0;
      wr_cnt        <= '0;
      rd_addr       <= '0;
      rd_buf        <= '0;
      rd_valid      <= 1'b0;
      rd_cnt        <= '0;
      drop_cnt      <= '0;
      repeat_cnt    <= '0;
    end else begin
      buf_st        <= st_nxt;
      wr_frame_done <= wr_complete;
      if (wr_sop) begin
        wr_active <= 1'b1;
        wr_buf    <= wr_new_idx;
        wr_cnt    <= '0;
        wr_addr   <= region_base(wr_new_idx);
      end else if (wr_active && wr_burst_done) begin
        if (wr_complete) begin
          wr_active <= 1'b0;
        end else begin
          wr_cnt  <= wr_cnt + 1'b1;
          wr_addr <= wr_addr + ADDR_W'(BURST_LEN);
        end
      end
      if (rd_sop) begin
        rd_cnt <= '0;
        if (rd_take) begin
          rd_buf   <= rd_take_idx;
          rd_valid <= 1'b1;
          rd_addr  <= region_base(rd_take_idx);
        end else if (rd_valid) begin
          rd_addr <= region_base(rd_buf);
          if (repeat_cnt != '1) repeat_cnt <= repeat_cnt + 1'b1;
        end else begin
          rd_addr <= '0;
          rd_buf  <= '0;
        end
      end else if (rd_burst_done && rd_cnt < CW'(NB)) begin
        rd_cnt  <= rd_cnt + 1'b1;
        rd_addr <= (rd_cnt == CW'(NB - 1)) ? region_base(rd_buf)
                                           : rd_addr + ADDR_W'(BURST_LEN);
      end
      if ((drop_cmp || drop_wr) && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_buf_mgr.sv
// Directed bench for frame_buf_mgr: a 3-buffer instance for the main
// rotation/drop/repeat flow and a 2-buffer instance for the overwrite case.
module tb_frame_buf_mgr;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned CNT_W  = 16;

  logic clk;
  logic rst;

  logic              a_wr_sop, a_wr_burst_done, a_rd_sop, a_rd_burst_done;
  logic [ADDR_W-1:0] a_wr_addr, a_rd_addr;
  logic [1:0]        a_wr_buf, a_rd_buf;
  logic              a_wr_active, a_wr_frame_done, a_rd_valid;
  logic [CNT_W-1:0]  a_drop_cnt, a_repeat_cnt;

  logic              b_wr_sop, b_wr_burst_done, b_rd_sop, b_rd_burst_done;
  logic [ADDR_W-1:0] b_wr_addr, b_rd_addr;
  logic [1:0]        b_wr_buf, b_rd_buf;
  logic              b_wr_active, b_wr_frame_done, b_rd_valid;
  logic [CNT_W-1:0]  b_drop_cnt, b_repeat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  frame_buf_mgr #(
    .NUM_BUF(3), .ADDR_W(ADDR_W), .BUF_SHIFT(12),
    .FRAME_WORDS(1024), .BURST_LEN(256), .CNT_W(CNT_W)
  ) u_a (
    .clk(clk), .rst(rst),
    .wr_sop(a_wr_sop), .wr_burst_done(a_wr_burst_done),
    .wr_addr(a_wr_addr), .wr_buf(a_wr_buf), .wr_active(a_wr_active),
    .wr_frame_done(a_wr_frame_done),
    .rd_sop(a_rd_sop), .rd_burst_done(a_rd_burst_done),
    .rd_addr(a_rd_addr), .rd_buf(a_rd_buf), .rd_valid(a_rd_valid),
    .drop_cnt(a_drop_cnt), .repeat_cnt(a_repeat_cnt)
  );

  frame_buf_mgr #(
    .NUM_BUF(2), .ADDR_W(ADDR_W), .BUF_SHIFT(12),
    .FRAME_WORDS(1024), .BURST_LEN(256), .CNT_W(CNT_W)
  ) u_b (
    .clk(clk), .rst(rst),
    .wr_sop(b_wr_sop), .wr_burst_done(b_wr_burst_done),
    .wr_addr(b_wr_addr), .wr_buf(b_wr_buf), .wr_active(b_wr_active),
    .wr_frame_done(b_wr_frame_done),
    .rd_sop(b_rd_sop), .rd_burst_done(b_rd_burst_done),
    .rd_addr(b_rd_addr), .rd_buf(b_rd_buf), .rd_valid(b_rd_valid),
    .drop_cnt(b_drop_cnt), .repeat_cnt(b_repeat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input logic ws, input logic wb, input logic rs, input logic rb);
    a_wr_sop = ws; a_wr_burst_done = wb; a_rd_sop = rs; a_rd_burst_done = rb;
    step();
    a_wr_sop = 1'b0; a_wr_burst_done = 1'b0; a_rd_sop = 1'b0; a_rd_burst_done = 1'b0;
  endtask

  task automatic pulse_b(input logic ws, input logic wb, input logic rs, input logic rb);
    b_wr_sop = ws; b_wr_burst_done = wb; b_rd_sop = rs; b_rd_burst_done = rb;
    step();
    b_wr_sop = 1'b0; b_wr_burst_done = 1'b0; b_rd_sop = 1'b0; b_rd_burst_done = 1'b0;
  endtask

  initial begin
    a_wr_sop = 0; a_wr_burst_done = 0; a_rd_sop = 0; a_rd_burst_done = 0;
    b_wr_sop = 0; b_wr_burst_done = 0; b_rd_sop = 0; b_rd_burst_done = 0;
    rst = 1'b1;
    step();
    step();
    check("rst_wr_addr",   32'(a_wr_addr), 32'h0);
    check("rst_wr_active", 32'(a_wr_active), 32'h0);
    check("rst_rd_valid",  32'(a_rd_valid), 32'h0);
    check("rst_rd_addr",   32'(a_rd_addr), 32'h0);
    check("rst_drop",      32'(a_drop_cnt), 32'h0);
    check("rst_repeat",    32'(a_repeat_cnt), 32'h0);
    check("rst_buf0",      32'(u_a.buf_st[0]), 32'h0);
    rst = 1'b0;

    // Scenario 1: first frame into buf0
    pulse_a(0, 1, 0, 0);
    check("idle_burst_ignored", 32'(a_wr_addr), 32'h0);
    check("idle_burst_active",  32'(a_wr_active), 32'h0);
    pulse_a(1, 0, 0, 0);
    check("s1_wr_buf",    32'(a_wr_buf), 32'h0);
    check("s1_wr_addr",   32'(a_wr_addr), 32'h0);
    check("s1_wr_active", 32'(a_wr_active), 32'h1);
    for (int k = 1; k <= 3; k++) begin
      pulse_a(0, 1, 0, 0);
      check("s1_burst_addr", 32'(a_wr_addr), 32'(k * 256));
    end
    pulse_a(0, 1, 0, 0);
    check("s1_frame_done", 32'(a_wr_frame_done), 32'h1);
    check("s1_inactive",   32'(a_wr_active), 32'h0);
    check("s1_addr_hold",  32'(a_wr_addr), 32'h300);
    check("s1_buf0_ready", 32'(u_a.buf_st[0]), 32'h2);
    step();
    check("s1_done_pulse", 32'(a_wr_frame_done), 32'h0);

    // Scenario 2: reader claims buf0 while writer starts buf1
    pulse_a(1, 0, 1, 0);
    check("s2_rd_buf",   32'(a_rd_buf), 32'h0);
    check("s2_rd_valid", 32'(a_rd_valid), 32'h1);
    check("s2_rd_addr",  32'(a_rd_addr), 32'h0);
    check("s2_wr_buf",   32'(a_wr_buf), 32'h1);
    check("s2_wr_addr",  32'(a_wr_addr), 32'h1000);
    check("s2_buf0_rd",  32'(u_a.buf_st[0]), 32'h3);

    // Scenario 3: two frames with no reader, second drops the first
    for (int k = 0; k < 4; k++) pulse_a(0, 1, 0, 0);
    check("s3_buf1_ready", 32'(u_a.buf_st[1]), 32'h2);
    pulse_a(1, 0, 0, 0);
    check("s3_wr_buf",  32'(a_wr_buf), 32'h2);
    check("s3_wr_addr", 32'(a_wr_addr), 32'h2000);
    for (int k = 0; k < 4; k++) pulse_a(0, 1, 0, 0);
    check("s3_drop",       32'(a_drop_cnt), 32'h1);
    check("s3_buf1_free",  32'(u_a.buf_st[1]), 32'h0);
    check("s3_buf2_ready", 32'(u_a.buf_st[2]), 32'h2);
    pulse_a(0, 0, 1, 0);
    check("s3_rd_buf",    32'(a_rd_buf), 32'h2);
    check("s3_rd_addr",   32'(a_rd_addr), 32'h2000);
    check("s3_buf0_free", 32'(u_a.buf_st[0]), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      pulse_a(0, 0, 0, 1);
      check("s3_rd_step", 32'(a_rd_addr), 32'h2000 + 32'(k * 256));
    end
    pulse_a(0, 0, 0, 1);
    check("s3_rd_wrap", 32'(a_rd_addr), 32'h2000);
    pulse_a(0, 0, 0, 1);
    check("s3_rd_sat",  32'(a_rd_addr), 32'h2000);

    // Scenario 4: repeat frames
    pulse_a(0, 0, 1, 0);
    check("s4_rd_buf", 32'(a_rd_buf), 32'h2);
    check("s4_rd_addr", 32'(a_rd_addr), 32'h2000);
    check("s4_repeat1", 32'(a_repeat_cnt), 32'h1);
    pulse_a(0, 0, 0, 1);
    check("s4_rd_adv", 32'(a_rd_addr), 32'h2100);
    pulse_a(0, 0, 1, 0);
    check("s4_rewind", 32'(a_rd_addr), 32'h2000);
    check("s4_repeat2", 32'(a_repeat_cnt), 32'h2);

    // Scenario 5: abort after two bursts; wr_sop beats a same-cycle burst
    pulse_a(1, 0, 0, 0);
    check("s5_wr_buf", 32'(a_wr_buf), 32'h0);
    pulse_a(0, 1, 0, 0);
    pulse_a(0, 1, 0, 0);
    check("s5_mid_addr", 32'(a_wr_addr), 32'h200);
    pulse_a(1, 1, 0, 0);
    check("s5_reuse_buf",  32'(a_wr_buf), 32'h0);
    check("s5_reuse_addr", 32'(a_wr_addr), 32'h0);
    check("s5_drop",       32'(a_drop_cnt), 32'h2);
    check("s5_active",     32'(a_wr_active), 32'h1);
    check("s5_buf0_wr",    32'(u_a.buf_st[0]), 32'h1);
    pulse_a(0, 1, 0, 0);
    check("s5_cnt_cleared", 32'(a_wr_addr), 32'h100);
    check("s5_rd_kept",     32'(a_rd_valid), 32'h1);

    // Scenario 6: two buffers, overwrite READY, completion + rd_sop together
    pulse_b(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) pulse_b(0, 1, 0, 0);
    pulse_b(0, 0, 1, 0);
    check("s6_rd_buf0", 32'(b_rd_buf), 32'h0);
    pulse_b(1, 0, 0, 0);
    check("s6_wr_buf1", 32'(b_wr_buf), 32'h1);
    for (int k = 0; k < 4; k++) pulse_b(0, 1, 0, 0);
    check("s6_buf1_ready", 32'(u_b.buf_st[1]), 32'h2);
    check("s6_drop0",      32'(b_drop_cnt), 32'h0);
    pulse_b(1, 0, 0, 0);
    check("s6_ovr_buf",  32'(b_wr_buf), 32'h1);
    check("s6_ovr_addr", 32'(b_wr_addr), 32'h1000);
    check("s6_ovr_drop", 32'(b_drop_cnt), 32'h1);
    check("s6_ovr_wr",   32'(u_b.buf_st[1]), 32'h1);
    for (int k = 0; k < 3; k++) pulse_b(0, 1, 0, 0);
    pulse_b(0, 1, 1, 0);
    check("s6_rd_buf1",   32'(b_rd_buf), 32'h1);
    check("s6_rd_addr",   32'(b_rd_addr), 32'h1000);
    check("s6_done",      32'(b_wr_frame_done), 32'h1);
    check("s6_buf0_free", 32'(u_b.buf_st[0]), 32'h0);
    check("s6_buf1_rd",   32'(u_b.buf_st[1]), 32'h3);
    check("s6_drop_kept", 32'(b_drop_cnt), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_buf_mgr.md
Name: frame_buf_mgr

Overview:
- Parametrised N-buffer frame-buffer manager for the capture → SDRAM → VGA path. It replaces the fixed single-region addressing with 2..4 rotating frame regions.
- Sits in the 100 MHz SDRAM-controller domain. It tracks the ownership of each buffer (FREE/WRITING/READY/READING) and generates burst base addresses for the write and read engines.
- On its reader side it drops stale frames and repeats frames, so the display always sees a complete frame and never tears.

Parameters:
- NUM_BUF, 3, number of frame regions (2..4).
- ADDR_W, 24, SDRAM word-address width.
- BUF_SHIFT, 19, log2 of region size in words; region base = buf_idx << BUF_SHIFT.
- FRAME_WORDS, 307200, words per frame (640x480 RGB565).
- BURST_LEN, 256, words per burst; FRAME_WORDS must be a multiple of it.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk, in, 1: controller clock.
- rst, in, 1: synchronous, active-high reset.
- wr_sop, in, 1: pulse; the writer starts a new frame.
- wr_burst_done, in, 1: pulse; one write burst has completed.
- wr_addr, out, ADDR_W: start address of the next write burst.
- wr_buf, out, 2: index of the buffer being written.
- wr_active, out, 1: a write frame is in progress.
- wr_frame_done, out, 1: one-cycle pulse when the last burst of a frame completes.
- rd_sop, in, 1: pulse; the display starts a new frame (vsync).
- rd_burst_done, in, 1: pulse; one read burst has completed.
- rd_addr, out, ADDR_W: start address of the next read burst.
- rd_buf, out, 2: index of the buffer being read.
- rd_valid, out, 1: the read buffer holds a complete frame.
- drop_cnt, out, CNT_W: frames discarded (saturating).
- repeat_cnt, out, CNT_W: frames re-displayed (saturating).

Behaviour:
- Reset: every buffer FREE; all outputs 0.
- Latency: every output is registered and updates on the cycle after its causing pulse.
- Per-buffer state is 2 bits: FREE, WRITING, READY, READING. At most one buffer is WRITING, at most one READY, at most one READING.
- Bursts per frame: NB = FRAME_WORDS / BURST_LEN.
- wr_sop, step 1: if wr_active, the current WRITING buffer is aborted → FREE, and drop_cnt increments.
- wr_sop, step 2: the new buffer is the lowest-index FREE buffer. If none is FREE (only possible with NUM_BUF=2), the READY buffer is overwritten and drop_cnt increments.
- wr_sop, step 3: the chosen buffer becomes WRITING; wr_active=1; the burst counter clears; wr_addr = base.
- wr_burst_done while wr_active: the burst counter increments and wr_addr = base + cnt*BURST_LEN.
- On burst NB:
  - the buffer becomes READY;
  - any previously READY buffer → FREE, and drop_cnt increments;
  - wr_frame_done pulses and wr_active=0;
  - wr_addr holds its last value.
- wr_burst_done while !wr_active is ignored.
- rd_sop with a READY buffer: the current READING buffer (if any) → FREE; the READY buffer → READING; rd_valid=1; the read counter clears; rd_addr = base.
- rd_sop with no READY buffer: the READING buffer is kept and rd_addr rewinds to its base. If rd_valid, repeat_cnt increments; if !rd_valid, rd_addr = 0 and rd_buf = 0.
- rd_burst_done: rd_addr advances by BURST_LEN. After NB bursts, rd_addr wraps to the base and the counter saturates until the next rd_sop.
- Same cycle, write completion and rd_sop: completion is applied first, so the reader claims the just-completed buffer.
- Same cycle, wr_sop and rd_sop: the reader's claim is applied first, and the writer's FREE search excludes the buffer the reader takes.
- Same cycle, wr_sop and wr_burst_done: wr_sop wins and the burst is discarded.
- Statistics counters saturate at all-ones.
- rst mid-operation: all state returns to the reset values on the next edge. In-flight bursts are not tracked.

Decomposition:
- Shared header frame_buf_pkg holds:
  - the state encodings (FREE=0, WRITING=1, READY=2, READING=3);
  - the default geometry constants, so sdram_controller and this block use identical values.
- One sub-module, buf_pick: a combinational lowest-index FREE priority encoder with an exclusion mask. It outputs the index and a found flag.

Test Plan:
Common setup for all scenarios: NUM_BUF=3, FRAME_WORDS=1024, BURST_LEN=256, BUF_SHIFT=12, so NB=4.
1. Reset, then wr_sop → wr_buf=0 and wr_addr=0x000. After 4 wr_burst_done pulses, wr_addr steps 0x100, 0x200, 0x300, then wr_frame_done pulses and buf0 is READY.
2. After scenario 1, rd_sop → rd_buf=0, rd_valid=1, rd_addr=0x000. Concurrently, wr_sop → wr_buf=1 and wr_addr=0x1000.
3. Complete two write frames (buf1, then buf2) without any rd_sop → drop_cnt=1 and buf1 FREE. Then rd_sop → rd_buf=2, rd_addr=0x2000, and buf0 FREE.
4. rd_sop with no new READY buffer → rd_buf is unchanged, rd_addr rewinds to its base, and repeat_cnt increments by 1.
5. wr_sop after 2 of 4 bursts → the aborted buffer is FREE, drop_cnt increments, and the lowest FREE index is reused.
6. NUM_BUF=2, one buffer READING and one READY, then wr_sop → the READY buffer is overwritten (becomes WRITING) and drop_cnt increments. The last write burst and rd_sop in the same cycle → the reader gets the new buffer.
